uart_rx_byte: RTL

- 8N1 UART receiver that deserialises the serial rx line into bytes. Bytes are presented with a single-cycle valid strobe.
- Sits directly upstream of the character-conversion datapath in lab1: rx pin -> uart_rx_byte -> case conversion -> transmitter -> tx pin.
- Matches the bench UART framing: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.

---
 rtl/uart_rx_byte.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronised rx, centre-of-bit sampling,
// one-cycle rxready / frame_error strobes and a busy flag.
module uart_rx_byte #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rxready,
  output logic       frame_error,
  output logic       busy
);

  localparam int BIT_PERIOD  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       bit_index, bit_index_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       dout_next;
  logic             rxready_next, frame_error_next;
  logic             rx_meta, rx_s;

  // Synchroniser flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      bit_index   <= '0;
      shift       <= '0;
      dout        <= '0;
      rxready     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      bit_index   <= bit_index_next;
      shift       <= shift_next;
      dout        <= dout_next;
      rxready     <= rxready_next;
      frame_error <= frame_error_next;
    end
  end

  always_comb begin
    state_next       = state;
    count_next       = count;
    bit_index_next   = bit_index;
    shift_next       = shift;
    dout_next        = dout;
    rxready_next     = 1'b0;
    frame_error_next = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          count_next = '0;
        end
      end

      // A start bit that is high again at its centre was only a glitch.
      START: begin
        if (count == HALF_LAST) begin
          count_next = '0;
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next     = DATA;
            bit_index_next = '0;
          end
        end else begin
          count_next = count + CNT_W'(1);
        end
      end

      DATA: begin
        if (count == BIT_LAST) begin
          count_next     = '0;
          shift_next     = {rx_s, shift[7:1]};
          bit_index_next = bit_index + 3'd1;
          if (bit_index == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          count_next = count + CNT_W'(1);
        end
      end

      // Leaving at mid-stop-bit gives half a bit to catch a back-to-back start.
      STOP: begin
        if (count == BIT_LAST) begin
          count_next = '0;
          if (rx_s) begin
            dout_next    = shift;
            rxready_next = 1'b1;
            state_next   = IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = WAIT_HIGH;
          end
        end else begin
          count_next = count + CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
